seq_det_ctrl: RTL and testbench
===============================

Name: seq_det_ctrl

Overview:
Programmable serial sequence-detector controller, generalising the fixed "101" detector.
- Holds a software-loaded pattern (length 1..PAT_MAX), arms and disarms detection, and gates the serial input.
- Supports overlapping or non-overlapping matches; counts matches.
- Sits between the config/control master and the serial bit source.

Parameters:
PAT_MAX, 8, maximum pattern length in bits (>=2)
CNT_W, 8, match counter width

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
cfg_valid  input  1  config request
cfg_ready  output  1  config accepted when valid&&ready
cfg_pattern  input  PAT_MAX  pattern; bit0 = most recent bit
cfg_len  input  $clog2(PAT_MAX+1)  pattern length
cfg_overlap  input  1  1 = overlapping matches
start  input  1  arm detector
stop  input  1  disarm detector
x_valid  input  1  serial bit qualifier
x  input  1  serial bit
z  output  1  registered match pulse
busy  output  1  high when not IDLE
cnt_clr  input  1  clear match counter
match_cnt  output  CNT_W  saturating match count
irq  output  1  sticky match interrupt (optional feature)
irq_ack  input  1  clear irq

Behaviour:
- Clock is clk. reset is synchronous, active-high.
- Reset values: state=IDLE, history=0, fill=0, z=0, match_cnt=0, irq=0.
- Reset config: pattern=...0101, len=3, overlap=1.
- cfg_ready = (state==IDLE).
- Config handshake:
  - On valid&&ready, latch pattern, len and overlap.
  - cfg_len 0 is loaded as 1; cfg_len >PAT_MAX is clamped to PAT_MAX.
- FSM states: IDLE, FILL, RUN.
  - IDLE: start -> FILL with fill=0 and history=0. Config and start in the same cycle: config is latched and the run uses the new config.
  - FILL: each x_valid shifts history <= {history[PAT_MAX-2:0], x} and increments fill. When fill reaches len, go to RUN.
  - RUN: each x_valid shifts history; fill saturates at len.
  - FILL/RUN: stop -> IDLE. stop has priority over a same-cycle x_valid; that sample is discarded and no match is reported.
  - start while not IDLE is ignored.
- Match is evaluated on the post-shift history when x_valid is high and (fill+1)>=len. The low len bits must equal the pattern's low len bits.
- z is high exactly one cycle, in the cycle after the matching sample (latency 1). z=0 when x_valid=0.
- Non-overlap mode: a match forces next state FILL with fill=0; history is kept but not reused.
- Overlap mode: stay in RUN.
- match_cnt increments on each match and saturates at 2^CNT_W-1.
  - cnt_clr has priority: a same-cycle match is not counted, result 0.
- Reset mid-operation returns to IDLE within one cycle and restores the default config.

Optional Feature:
SEQ_DET_IRQ_EN:
- Defined: irq is set the cycle z asserts and held until irq_ack. If set and ack occur in the same cycle, set wins.
- Undefined: irq tied 0 and irq_ack ignored; no irq flop is instantiated.

Decomposition:
- Package seq_det_pkg holds:
  - state enum {IDLE, FILL, RUN}
  - defaults DEF_PATTERN=101, DEF_LEN=3, DEF_OVERLAP=1
- One natural sub-module, seq_det_match: combinational masked compare of history vs pattern over len bits.

Test Plan:
- Defaults, start, stream 1,0,1,0,1 -> z pulses after samples 3 and 5; match_cnt=2.
- cfg overlap=0, same stream -> z only after sample 3; match_cnt=1.
- cfg pattern=1101, len=4, stream 1,1,0,1,1,0,1 (overlap=1) -> z after samples 4 and 7; x_valid gaps don't shift history.
- RUN, then cfg_valid=1 -> cfg_ready=0 and config unchanged; stop in the same cycle as a completing sample -> no z, state IDLE, cfg_ready=1 next cycle.
- CNT_W=2, 5 matches -> match_cnt=3; cnt_clr with a simultaneous match -> 0.
- reset asserted mid-RUN -> next cycle busy=0, z=0, match_cnt=0, default config; 101 is detected again after start.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and reset-time defaults for the programmable sequence detector.
// Optional sticky interrupt is enabled in the top with SEQ_DET_IRQ_EN.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Default pattern is "101", bit0 being the most recent sample.
  localparam int   DEF_PATTERN = 5;
  localparam int   DEF_LEN     = 3;
  localparam logic DEF_OVERLAP = 1'b1;

endpackage

// File: rtl/seq_det_match.sv
// Combinational compare of the low i_len bits of the shift history
// against the loaded pattern; bits at or above i_len are ignored.
module seq_det_match
  import seq_det_pkg::*;
#(
  parameter int PAT_MAX = 8,
  parameter int LEN_W   = $clog2(PAT_MAX + 1)
) (
  input  logic [PAT_MAX-1:0] i_hist,
  input  logic [PAT_MAX-1:0] i_pattern,
  input  logic [LEN_W-1:0]   i_len,
  output logic               o_match
);

  logic [PAT_MAX-1:0] w_mask;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < PAT_MAX; i++) begin
      if (i < int'(i_len)) w_mask[i] = 1'b1;
    end
  end

  assign o_match = (((i_hist ^ i_pattern) & w_mask) == '0);

endmodule

// File: rtl/seq_det_ctrl.sv
// Programmable serial sequence detector: config handshake, IDLE/FILL/RUN
// control, overlap/non-overlap matching, saturating match counter.
// Define SEQ_DET_IRQ_EN to add a sticky match interrupt cleared by irq_ack.
//
// Config handshake: a transfer happens on a rising clk edge where
// cfg_valid && cfg_ready; cfg_ready is high only in IDLE, and the master
// holds its request until accepted.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int PAT_MAX = 8,
  parameter int CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [PAT_MAX-1:0]           cfg_pattern,
  input  logic [$clog2(PAT_MAX+1)-1:0] cfg_len,
  input  logic                         cfg_overlap,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         x_valid,
  input  logic                         x,
  output logic                         z,
  output logic                         busy,
  input  logic                         cnt_clr,
  output logic [CNT_W-1:0]             match_cnt,
  output logic                         irq,
  input  logic                         irq_ack,
  output logic [1:0]                   dbg_state
);

  localparam int LEN_W = $clog2(PAT_MAX + 1);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_MAX);

  state_t             r_state, w_state_nxt;
  logic [PAT_MAX-1:0] r_hist, w_hist_nxt;
  logic [LEN_W-1:0]   r_fill, w_fill_nxt;
  logic [PAT_MAX-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic               r_z;
  logic [CNT_W-1:0]   r_cnt;

  logic [LEN_W-1:0]   w_cfg_len;
  logic [LEN_W:0]     w_fill_inc;
  logic [LEN_W:0]     w_len_ext;
  logic [PAT_MAX-1:0] w_hist_shift;
  logic               w_active;
  logic               w_eval;
  logic               w_cmp;
  logic               w_match;
  logic               w_cfg_fire;

  assign cfg_ready  = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign dbg_state  = r_state;
  assign z          = r_z;
  assign match_cnt  = r_cnt;
  assign w_cfg_fire = cfg_valid && cfg_ready;

  // Length 0 would match everything; treat it as a single-bit pattern.
  always_comb begin
    w_cfg_len = cfg_len;
    if (cfg_len == '0)          w_cfg_len = LEN_W'(1);
    else if (cfg_len > MAX_LEN) w_cfg_len = MAX_LEN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pattern <= PAT_MAX'(DEF_PATTERN);
      r_len     <= LEN_W'(DEF_LEN);
      r_overlap <= DEF_OVERLAP;
    end else if (w_cfg_fire) begin
      r_pattern <= cfg_pattern;
      r_len     <= w_cfg_len;
      r_overlap <= cfg_overlap;
    end
  end

  assign w_fill_inc   = {1'b0, r_fill} + (LEN_W + 1)'(1);
  assign w_len_ext    = {1'b0, r_len};
  assign w_hist_shift = {r_hist[PAT_MAX-2:0], x};
  assign w_active     = (r_state != IDLE);
  // stop wins over a same-cycle sample, so such a sample never matches.
  assign w_eval       = w_active && !stop && x_valid && (w_fill_inc >= w_len_ext);
  assign w_match      = w_eval && w_cmp;

  seq_det_match #(
    .PAT_MAX (PAT_MAX),
    .LEN_W   (LEN_W)
  ) u_match (
    .i_hist    (w_hist_shift),
    .i_pattern (r_pattern),
    .i_len     (r_len),
    .o_match   (w_cmp)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_hist  <= '0;
      r_fill  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hist  <= w_hist_nxt;
      r_fill  <= w_fill_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hist_nxt  = r_hist;
    w_fill_nxt  = r_fill;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = FILL;
          w_hist_nxt  = '0;
          w_fill_nxt  = '0;
        end
      end
      FILL, RUN: begin
        if (stop) begin
          w_state_nxt = IDLE;
        end else if (x_valid) begin
          w_hist_nxt = w_hist_shift;
          if (w_fill_inc >= w_len_ext) begin
            w_state_nxt = RUN;
            w_fill_nxt  = r_len;
          end else begin
            w_fill_nxt  = w_fill_inc[LEN_W-1:0];
          end
          // Non-overlap: restart the fill count so matched bits are not reused.
          if (w_match && !r_overlap) begin
            w_state_nxt = FILL;
            w_fill_nxt  = '0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_z <= 1'b0;
    else       r_z <= w_match;
  end

  always_ff @(posedge clk) begin
    if (reset)                        r_cnt <= '0;
    else if (cnt_clr)                 r_cnt <= '0;
    else if (w_match && r_cnt != '1)  r_cnt <= r_cnt + CNT_W'(1);
  end

`ifdef SEQ_DET_IRQ_EN
  logic r_irq;

  // Set has priority over a same-cycle acknowledge.
  always_ff @(posedge clk) begin
    if (reset)        r_irq <= 1'b0;
    else if (w_match) r_irq <= 1'b1;
    else if (irq_ack) r_irq <= 1'b0;
  end

  assign irq = r_irq;
`else
  logic w_unused_irq_ack;
  assign w_unused_irq_ack = irq_ack;
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl (PAT_MAX=8, CNT_W=2) with hand-computed
// expectations for match pulses, counter, state and config behaviour.
module tb_seq_det_ctrl;

  localparam int PAT_MAX = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = $clog2(PAT_MAX + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic               clk = 1'b0;
  logic               reset;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [PAT_MAX-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               start;
  logic               stop;
  logic               x_valid;
  logic               x;
  logic               z;
  logic               busy;
  logic               cnt_clr;
  logic [CNT_W-1:0]   match_cnt;
  logic               irq;
  logic               irq_ack;
  logic [1:0]         dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  seq_det_ctrl #(
    .PAT_MAX (PAT_MAX),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .start       (start),
    .stop        (stop),
    .x_valid     (x_valid),
    .x           (x),
    .z           (z),
    .busy        (busy),
    .cnt_clr     (cnt_clr),
    .match_cnt   (match_cnt),
    .irq         (irq),
    .irq_ack     (irq_ack),
    .dbg_state   (dbg_state)
  );

  // Clock/reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b);
    x_valid = 1'b1;
    x       = b;
    tick();
    x_valid = 1'b0;
  endtask

  task automatic configure(input logic [PAT_MAX-1:0] pat, input logic [LEN_W-1:0] len,
                           input logic ovl, input logic with_start);
    cfg_valid   = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    cnt_clr     = 1'b1;
    start       = with_start;
    tick();
    cfg_valid   = 1'b0;
    cnt_clr     = 1'b0;
    start       = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    start = 1'b0; stop = 1'b0; x_valid = 1'b0; x = 1'b0; cnt_clr = 1'b0; irq_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_busy",  busy, 0);
    check("rst_z",     z, 0);
    check("rst_cnt",   match_cnt, 0);
    check("rst_ready", cfg_ready, 1);
    check("rst_state", dbg_state, S_IDLE);
    check("rst_irq",   irq, 0);

    // Default config 101 overlapping: stream 1,0,1,0,1
    do_start();
    check("t1_busy",  busy, 1);
    check("t1_state", dbg_state, S_FILL);
    send(1); check("t1_z1", z, 0);
    send(0); check("t1_z2", z, 0);
    send(1); check("t1_z3", z, 1);
    check("t1_state_run", dbg_state, S_RUN);
    send(0); check("t1_z4", z, 0);
    send(1); check("t1_z5", z, 1);
    tick();  check("t1_z_idle", z, 0);
    check("t1_cnt", match_cnt, 2);
`ifdef SEQ_DET_IRQ_EN
    check("t1_irq_set", irq, 1);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("t1_irq_ack", irq, 0);
`else
    check("t1_irq_off", irq, 0);
`endif
    do_stop();
    check("t1_stop_state", dbg_state, S_IDLE);

    // Non-overlap, config and start in the same cycle
    configure(8'b101, 4'd3, 1'b0, 1'b1);
    check("t2_state", dbg_state, S_FILL);
    send(1); check("t2_z1", z, 0);
    send(0); check("t2_z2", z, 0);
    send(1); check("t2_z3", z, 1);
    check("t2_refill", dbg_state, S_FILL);
    send(0); check("t2_z4", z, 0);
    send(1); check("t2_z5", z, 0);
    check("t2_cnt", match_cnt, 1);
    do_stop();

    // Pattern 1101 len 4 overlapping, with x_valid gaps
    configure(8'b1101, 4'd4, 1'b1, 1'b0);
    check("t3_cnt_clr", match_cnt, 0);
    do_start();
    send(1); tick();
    send(1);
    send(0); tick();
    send(1); check("t3_z4", z, 1);
    send(1); check("t3_z5", z, 0);
    send(0); check("t3_z6", z, 0);
    tick(); tick();
    send(1); check("t3_z7", z, 1);
    check("t3_cnt", match_cnt, 2);

    // Config request while running is refused and leaves config unchanged
    cfg_valid = 1'b1; cfg_pattern = 8'b00; cfg_len = 4'd2; cfg_overlap = 1'b0;
    check("t4_ready_run", cfg_ready, 0);
    tick();
    cfg_valid = 1'b0;
    send(1); check("t4_z_a", z, 0);
    send(1); check("t4_z_b", z, 0);
    send(0); check("t4_z_c", z, 0);
    send(1); check("t4_z_keep", z, 1);
    check("t4_cnt", match_cnt, 3);
    send(1);
    send(0);
    // stop with a completing sample: sample discarded
    stop = 1'b1; x_valid = 1'b1; x = 1'b1;
    tick();
    stop = 1'b0; x_valid = 1'b0;
    check("t4_stop_z", z, 0);
    check("t4_stop_state", dbg_state, S_IDLE);
    check("t4_stop_ready", cfg_ready, 1);
    check("t4_stop_cnt", match_cnt, 3);

    // Saturation with CNT_W=2; cfg_len 0 is loaded as 1
    configure(8'b1, 4'd0, 1'b1, 1'b0);
    do_start();
    for (int i = 1; i <= 5; i++) begin
      send(1);
      check("t5_z", z, 1);
    end
    check("t5_sat", match_cnt, 3);
    cnt_clr = 1'b1;
    send(1);
    cnt_clr = 1'b0;
    check("t5_clr_z", z, 1);
    check("t5_clr_cnt", match_cnt, 0);
    do_stop();

    // cfg_len above PAT_MAX is clamped to PAT_MAX
    configure(8'hFF, 4'd15, 1'b1, 1'b1);
    for (int i = 1; i <= 9; i++) begin
      send(1);
      if (i == 7) check("t6_z7", z, 0);
      if (i == 8) check("t6_z8", z, 1);
    end
    check("t6_cnt", match_cnt, 2);

    // Reset mid-RUN restores defaults
    check("t7_pre_state", dbg_state, S_RUN);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t7_busy",  busy, 0);
    check("t7_z",     z, 0);
    check("t7_cnt",   match_cnt, 0);
    check("t7_ready", cfg_ready, 1);
    do_start();
    send(1); check("t7_z1", z, 0);
    send(0); check("t7_z2", z, 0);
    send(1); check("t7_z3", z, 1);
    check("t7_cnt_after", match_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
